boot_rom_arbiter: RTL and testbench

BOOT_ROM_ARBITER -- requirements
Module: boot_rom_arbiter

---
 rtl/boot_rom_arbiter.sv | 106 ++++++++++
 tb/tb_boot_rom_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/boot_rom_arbiter.sv
// Two-master arbiter in front of a single-port boot ROM with fixed one-cycle read latency.
// Define BOOT_ROM_ARB_RR_EN for round-robin arbitration; the default build is fixed priority (m0 > m1).

`ifndef ROM_ADDR_WIDTH
`define ROM_ADDR_WIDTH 16
`endif

module boot_rom_arbiter #(
  parameter int ADDR_WIDTH = `ROM_ADDR_WIDTH,
  parameter int DATA_WIDTH = 32,
  parameter int ROM_WORDS  = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  output logic                  m0_gnt_o,
  output logic                  m0_rvalid_o,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  output logic                  m0_err_o,
  input  logic                  m1_req_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  output logic                  m1_gnt_o,
  output logic                  m1_rvalid_o,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  output logic                  m1_err_o,
  output logic                  rom_en_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_rdata_i
);

  // Handshake: a master holds req/addr; gnt in the same cycle means accepted.
  // Response comes exactly one cycle later as a one-cycle rvalid pulse, no back-pressure.

  localparam logic [31:0] ROM_WORDS_U = ROM_WORDS;

  logic                  any_gnt;
  logic                  pick_m1;
  logic                  gnt_in_range;
  logic [ADDR_WIDTH-1:0] gnt_addr;
  logic [ADDR_WIDTH-1:0] last_addr_q;
  logic                  rsp_valid_q;
  logic                  rsp_owner_q;
  logic                  rsp_err_q;
  logic                  rsp_live;

`ifdef BOOT_ROM_ARB_RR_EN
  // rr_ptr_q names the preferred master; it flips whenever that master wins.
  logic rr_ptr_q;

  always_comb begin
    pick_m1 = m1_req_i;
    if (m0_req_i && m1_req_i) pick_m1 = rr_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q <= 1'b0;
    end else if (any_gnt && (pick_m1 == rr_ptr_q)) begin
      rr_ptr_q <= ~rr_ptr_q;
    end
  end
`else
  always_comb begin
    pick_m1 = m1_req_i && !m0_req_i;
  end
`endif

  always_comb begin
    any_gnt      = rst_n && (m0_req_i || m1_req_i);
    gnt_addr     = pick_m1 ? m1_addr_i : m0_addr_i;
    gnt_in_range = 32'(gnt_addr[ADDR_WIDTH-1:2]) < ROM_WORDS_U;
    m0_gnt_o     = any_gnt && !pick_m1;
    m1_gnt_o     = any_gnt && pick_m1;
    rom_en_o     = any_gnt && gnt_in_range;
    rom_addr_o   = rom_en_o ? gnt_addr : last_addr_q;
  end

  // Reset gates the response outputs even before the registers clear.
  always_comb begin
    rsp_live    = rst_n && rsp_valid_q;
    m0_rvalid_o = rsp_live && !rsp_owner_q;
    m1_rvalid_o = rsp_live && rsp_owner_q;
    m0_err_o    = m0_rvalid_o && rsp_err_q;
    m1_err_o    = m1_rvalid_o && rsp_err_q;
    m0_rdata_o  = (m0_rvalid_o && !rsp_err_q) ? rom_rdata_i : '0;
    m1_rdata_o  = (m1_rvalid_o && !rsp_err_q) ? rom_rdata_i : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_owner_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      last_addr_q <= '0;
    end else begin
      rsp_valid_q <= any_gnt;
      if (any_gnt) begin
        rsp_owner_q <= pick_m1;
        rsp_err_q   <= !gnt_in_range;
      end
      if (rom_en_o) last_addr_q <= gnt_addr;
    end
  end

endmodule

// File: tb/tb_boot_rom_arbiter.sv
// Bench for boot_rom_arbiter: directed scenarios then random traffic against a
// transaction-level model (winner rule, pending-response queue, ROM content function).

module tb_boot_rom_arbiter;

  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int WORDS = 1024;
  localparam int QW    = DW + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_req_i = 1'b0;
  logic [AW-1:0] m0_addr_i = '0;
  logic          m0_gnt_o;
  logic          m0_rvalid_o;
  logic [DW-1:0] m0_rdata_o;
  logic          m0_err_o;
  logic          m1_req_i = 1'b0;
  logic [AW-1:0] m1_addr_i = '0;
  logic          m1_gnt_o;
  logic          m1_rvalid_o;
  logic [DW-1:0] m1_rdata_o;
  logic          m1_err_o;
  logic          rom_en_o;
  logic [AW-1:0] rom_addr_o;
  logic [DW-1:0] rom_rdata_i = '0;

  int checks = 0;
  int errors = 0;

  // Each entry: {owner_is_m1, err, data}
  logic [QW-1:0] exp_q[$];
  bit            exp_ptr = 1'b0;
  logic [AW-1:0] exp_last = '0;

  boot_rom_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_gnt_o(m0_gnt_o),
    .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
    .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_gnt_o(m1_gnt_o),
    .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
    .rom_en_o(rom_en_o), .rom_addr_o(rom_addr_o), .rom_rdata_i(rom_rdata_i)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_word(input logic [31:0] idx);
    if (idx == 32'd2) return 32'hDEADBEEF;
    return (idx * 32'h9E3779B1) ^ 32'hA5A50000 ^ idx;
  endfunction

  // ROM: one-cycle latency; junk on the bus when not enabled.
  always @(posedge clk) begin
    if (rom_en_o) rom_rdata_i <= rom_word(32'(rom_addr_o[AW-1:2]));
    else          rom_rdata_i <= DW'($urandom);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cycle(input bit r, input bit q0, input logic [AW-1:0] a0,
                       input bit q1, input logic [AW-1:0] a1);
    bit            has_gnt, win_m1, in_rng, rsp_v, own1;
    logic [AW-1:0] gaddr;
    logic [QW-1:0] rsp;
    @(negedge clk);
    rst_n = r; m0_req_i = q0; m0_addr_i = a0; m1_req_i = q1; m1_addr_i = a1;
    #1;
    has_gnt = r && (q0 || q1);
`ifdef BOOT_ROM_ARB_RR_EN
    win_m1 = (q0 && q1) ? exp_ptr : q1;
`else
    win_m1 = q1 && !q0;
`endif
    gaddr  = win_m1 ? a1 : a0;
    in_rng = 32'(gaddr >> 2) < WORDS;
    rsp_v  = 1'b0;
    rsp    = '0;
    if (exp_q.size() > 0) begin
      rsp   = exp_q.pop_front();
      rsp_v = r;
    end
    own1 = rsp[QW-1];
    check("m0_gnt", m0_gnt_o, has_gnt && !win_m1);
    check("m1_gnt", m1_gnt_o, has_gnt && win_m1);
    check("rom_en", rom_en_o, has_gnt && in_rng);
    check("rom_addr", rom_addr_o, (has_gnt && in_rng) ? gaddr : exp_last);
    check("m0_rvalid", m0_rvalid_o, rsp_v && !own1);
    check("m1_rvalid", m1_rvalid_o, rsp_v && own1);
    check("m0_err", m0_err_o, rsp_v && !own1 && rsp[QW-2]);
    check("m1_err", m1_err_o, rsp_v && own1 && rsp[QW-2]);
    check("m0_rdata", m0_rdata_o, (rsp_v && !own1) ? rsp[DW-1:0] : '0);
    check("m1_rdata", m1_rdata_o, (rsp_v && own1) ? rsp[DW-1:0] : '0);
    if (!r) begin
      exp_q.delete();
      exp_ptr  = 1'b0;
      exp_last = '0;
    end else if (has_gnt) begin
      exp_q.push_back({win_m1, !in_rng, in_rng ? rom_word(32'(gaddr >> 2)) : {DW{1'b0}}});
      if (in_rng) exp_last = gaddr;
`ifdef BOOT_ROM_ARB_RR_EN
      if (win_m1 == exp_ptr) exp_ptr = !exp_ptr;
`endif
    end
  endtask

  initial begin
    bit            r, q0, q1;
    logic [AW-1:0] a0, a1;
    repeat (3) cycle(0, 0, '0, 0, '0);
    // single fetch of word 2, then back-to-back fetches
    cycle(1, 1, 16'h0008, 0, '0);
    cycle(1, 0, '0, 0, '0);
    cycle(1, 1, 16'h0000, 0, '0);
    cycle(1, 1, 16'h0004, 0, '0);
    cycle(1, 1, 16'h0008, 0, '0);
    cycle(1, 0, '0, 0, '0);
    // contention from a fresh pointer
    cycle(0, 0, '0, 0, '0);
    for (int i = 0; i < 4; i++) cycle(1, 1, AW'(16 + 4 * i), 1, AW'(32 + 4 * i));
    cycle(1, 0, '0, 0, '0);
    // out-of-range word 1024 from m1, plus a dropped request
    cycle(1, 0, '0, 1, 16'h1000);
    cycle(1, 0, '0, 0, '0);
    // reset right after a grant kills the response
    cycle(1, 1, 16'h0040, 0, '0);
    cycle(0, 1, 16'h0044, 1, 16'h0048);
    cycle(0, 0, '0, 0, '0);
    cycle(1, 1, 16'h0050, 1, 16'h0054);
    cycle(1, 0, '0, 0, '0);
    for (int i = 0; i < 1500; i++) begin
      r  = $urandom_range(0, 99) > 2;
      q0 = $urandom_range(0, 1) == 1;
      q1 = $urandom_range(0, 1) == 1;
      a0 = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, WORDS * 4 - 1));
      a1 = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, WORDS * 4 - 1));
      cycle(r, q0, a0, q1, a1);
    end
    cycle(1, 0, '0, 0, '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
